// File: rtl/line_win_3x3_if.sv
// Column-in / window-out stream bundle for line_win_3x3.
// The slave modport is the window block; the master modport is the
// environment that supplies columns and consumes windows.
interface line_win_3x3_if #(
  parameter int PX_WIDTH = 30
);
  logic [3*PX_WIDTH-1:0] col_tdata_i;
  logic                  col_tvalid_i;
  logic                  col_tready_o;
  logic                  col_tlast_i;
  logic                  col_tuser_i;
  logic [9*PX_WIDTH-1:0] win_tdata_o;
  logic                  win_tvalid_o;
  logic                  win_tready_i;
  logic                  win_tlast_o;
  logic                  win_tuser_o;

  modport slave (
    input  col_tdata_i, col_tvalid_i, col_tlast_i, col_tuser_i, win_tready_i,
    output col_tready_o, win_tdata_o, win_tvalid_o, win_tlast_o, win_tuser_o
  );

  modport master (
    output col_tdata_i, col_tvalid_i, col_tlast_i, col_tuser_i, win_tready_i,
    input  col_tready_o, win_tdata_o, win_tvalid_o, win_tlast_o, win_tuser_o
  );
endinterface

// File: rtl/line_win_3x3.sv
// line_win_3x3: builds one 3x3 neighbourhood window per accepted column
// of three vertically adjacent pixels, with horizontal border handling.
// Optional feature macro LINE_WIN_3X3_BORDER_REPL_EN: when defined the
// border columns replicate the edge column, otherwise they are zero.
//
// Column shift: the window emitted on an accepted column is (C, R, new),
// i.e. the left/centre/right registers after the shift L<=C, C<=R, R<=new.
// Because that window is formed directly from C, R and the incoming
// column, no separate L register is kept. On the first column of a line C
// is loaded with the left border value so the first window comes out as
// (border, first, second).
module line_win_3x3 #(
  parameter int PX_WIDTH      = 30,
  parameter int MAX_LINE_SIZE = 1920
) (
  input  logic               clk_i,
  input  logic               rst_i,
  line_win_3x3_if.slave      bus
);

  localparam int CNT_W = $clog2(MAX_LINE_SIZE + 1);
  localparam int COL_W = 3 * PX_WIDTH;
  localparam int WIN_W = 9 * PX_WIDTH;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [COL_W-1:0]   c_r;
  logic [COL_W-1:0]   r_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               pend_user_r;
  logic [WIN_W-1:0]   win_data_r;
  logic               win_valid_r;
  logic               win_last_r;
  logic               win_user_r;

  logic               load_en_s;
  logic               col_tready_s;
  logic               accept_s;
  logic               emit_s;
  logic [WIN_W-1:0]   win_nxt_s;
  logic               last_nxt_s;

  // Border column used outside the line edges.
  function automatic logic [COL_W-1:0] border_col(input logic [COL_W-1:0] edge_col);
`ifdef LINE_WIN_3X3_BORDER_REPL_EN
    return edge_col;
`else
    return {COL_W{1'b0}} & edge_col & {COL_W{1'b0}};
`endif
  endfunction

  // Assemble a window: element (row,col) at [(row*3+col)*PX_WIDTH +: PX_WIDTH].
  function automatic logic [WIN_W-1:0] pack_win(input logic [COL_W-1:0] l_col,
                                                 input logic [COL_W-1:0] m_col,
                                                 input logic [COL_W-1:0] r_col);
    logic [WIN_W-1:0] w;
    w = {WIN_W{1'b0}};
    for (int row = 0; row < 3; row++) begin
      w[(row*3+0)*PX_WIDTH +: PX_WIDTH] = l_col[row*PX_WIDTH +: PX_WIDTH];
      w[(row*3+1)*PX_WIDTH +: PX_WIDTH] = m_col[row*PX_WIDTH +: PX_WIDTH];
      w[(row*3+2)*PX_WIDTH +: PX_WIDTH] = r_col[row*PX_WIDTH +: PX_WIDTH];
    end
    return w;
  endfunction

  assign load_en_s        = !win_valid_r || bus.win_tready_i;
  assign col_tready_s     = load_en_s && (state_r != ST_FLUSH);
  assign accept_s         = bus.col_tvalid_i && col_tready_s;

  assign bus.col_tready_o = col_tready_s;
  assign bus.win_tdata_o  = win_data_r;
  assign bus.win_tvalid_o = win_valid_r;
  assign bus.win_tlast_o  = win_last_r;
  assign bus.win_tuser_o  = win_user_r;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_FIRST;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and the window to present when the output register loads.
  always_comb begin
    state_nxt_s = state_r;
    emit_s      = 1'b0;
    win_nxt_s   = {WIN_W{1'b0}};
    last_nxt_s  = 1'b0;
    case (state_r)
      ST_FIRST: begin
        if (accept_s) begin
          state_nxt_s = bus.col_tlast_i ? ST_FLUSH : ST_RUN;
        end else begin
          state_nxt_s = ST_FIRST;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          emit_s      = 1'b1;
          win_nxt_s   = pack_win(c_r, r_r, bus.col_tdata_i);
          state_nxt_s = bus.col_tlast_i ? ST_FLUSH : ST_RUN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (load_en_s) begin
          emit_s      = 1'b1;
          win_nxt_s   = pack_win(c_r, r_r, border_col(r_r));
          last_nxt_s  = 1'b1;
          state_nxt_s = ST_FIRST;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      default: begin
        state_nxt_s = ST_FIRST;
      end
    endcase
  end

  // Column registers, line counter, pending start-of-frame flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c_r         <= {COL_W{1'b0}};
      r_r         <= {COL_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      pend_user_r <= 1'b0;
    end else begin
      if (accept_s && (state_r == ST_FIRST)) begin
        c_r         <= border_col(bus.col_tdata_i);
        r_r         <= bus.col_tdata_i;
        cnt_r       <= CNT_W'(1);
        pend_user_r <= bus.col_tuser_i;
      end else if (accept_s) begin
        c_r <= r_r;
        r_r <= bus.col_tdata_i;
        if (cnt_r < CNT_W'(MAX_LINE_SIZE)) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else if (state_r == ST_FIRST) begin
        cnt_r <= {CNT_W{1'b0}};
      end
      // The flag rides on the first window of the line only.
      if (emit_s) begin
        pend_user_r <= 1'b0;
      end
    end
  end

  // Output window register; holds while the consumer stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_data_r  <= {WIN_W{1'b0}};
      win_valid_r <= 1'b0;
      win_last_r  <= 1'b0;
      win_user_r  <= 1'b0;
    end else if (load_en_s) begin
      win_valid_r <= emit_s;
      if (emit_s) begin
        win_data_r <= win_nxt_s;
        win_last_r <= last_nxt_s;
        win_user_r <= pend_user_r;
      end
    end
  end

endmodule

// File: tb/tb_line_win_3x3.sv
// Directed, table-driven bench for line_win_3x3.
module tb_line_win_3x3;

  localparam int PW  = 8;
  localparam int MAX = 16;

  typedef logic [3*PW-1:0] col_t;
  typedef logic [9*PW-1:0] win_t;

  typedef struct {
    col_t col;
    bit   last;
    bit   user;
    win_t exp_win;
    bit   exp_last;
    bit   exp_user;
  } vec_t;

  typedef struct {
    win_t win;
    bit   last;
    bit   user;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   nrdy = 0;
  vec_t tbl[$];
  obs_t obs[$];

  line_win_3x3_if #(.PX_WIDTH(PW)) b();

  line_win_3x3 #(.PX_WIDTH(PW), .MAX_LINE_SIZE(MAX)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b)
  );

  always #5 clk = ~clk;

  // Capture every window handed over to the consumer.
  always @(negedge clk) begin
    if (!rst && b.win_tvalid_o && b.win_tready_i) begin
      obs.push_back('{b.win_tdata_o, b.win_tlast_o, b.win_tuser_o});
    end
  end

  function automatic col_t mkcol(input int t, input int m, input int bo);
    return {PW'(bo), PW'(m), PW'(t)};
  endfunction

  function automatic col_t bord(input col_t c);
`ifdef LINE_WIN_3X3_BORDER_REPL_EN
    return c;
`else
    return c & {3*PW{1'b0}};
`endif
  endfunction

  function automatic win_t win_of(input col_t l, input col_t m, input col_t r);
    win_t w;
    for (int row = 0; row < 3; row++) begin
      w[(row*3+0)*PW +: PW] = l[row*PW +: PW];
      w[(row*3+1)*PW +: PW] = m[row*PW +: PW];
      w[(row*3+2)*PW +: PW] = r[row*PW +: PW];
    end
    return w;
  endfunction

  task automatic chk(input string nm, input logic [9*PW-1:0] act, input logic [9*PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input col_t c, input bit l, input bit u, input win_t w, input bit el, input bit eu);
    tbl.push_back('{c, l, u, w, el, eu});
  endtask

  task automatic put_col(input col_t d, input bit last, input bit user);
    bit r;
    int n;
    b.col_tdata_i  = d;
    b.col_tlast_i  = last;
    b.col_tuser_i  = user;
    b.col_tvalid_i = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      r = b.col_tready_o;
      if (!r) nrdy++;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 100) begin
        chk("col_accept_timeout", 1, 0);
        break;
      end
    end
    b.col_tvalid_i = 1'b0;
    b.col_tlast_i  = 1'b0;
    b.col_tuser_i  = 1'b0;
  endtask

  task automatic run_table(input string nm);
    int n;
    obs.delete();
    foreach (tbl[i]) put_col(tbl[i].col, tbl[i].last, tbl[i].user);
    n = 0;
    while (obs.size() < tbl.size() && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk($sformatf("%s_count", nm), obs.size(), tbl.size());
    foreach (tbl[i]) begin
      if (i < obs.size()) begin
        chk($sformatf("%s_win%0d", nm, i), obs[i].win, tbl[i].exp_win);
        chk($sformatf("%s_last%0d", nm, i), obs[i].last, tbl[i].exp_last);
        chk($sformatf("%s_user%0d", nm, i), obs[i].user, tbl[i].exp_user);
      end
    end
    tbl.delete();
  endtask

  // Hold the consumer off mid-line and check the output stays frozen.
  task automatic stall_seq();
    int n;
    win_t held;
    n = 0;
    while (obs.size() < 2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    b.win_tready_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b.win_tvalid_o && n < 50);
    chk("stall_valid", b.win_tvalid_o, 1);
    held = b.win_tdata_o;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall_hold%0d", k), b.win_tdata_o, held);
      chk($sformatf("stall_ready%0d", k), b.col_tready_o, 0);
      chk($sformatf("stall_vhold%0d", k), b.win_tvalid_o, 1);
    end
    @(posedge clk);
    #1;
    b.win_tready_i = 1'b1;
  endtask

  initial begin
    col_t c1, c2, c3, c4, c7, rw, d1, d2, d3, e1, e2, e3;
    b.col_tdata_i  = '0;
    b.col_tvalid_i = 1'b0;
    b.col_tlast_i  = 1'b0;
    b.col_tuser_i  = 1'b0;
    b.win_tready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_valid", b.win_tvalid_o, 0);
    chk("rst_last", b.win_tlast_o, 0);
    chk("rst_user", b.win_tuser_o, 0);
    chk("rst_data", b.win_tdata_o, 0);
    chk("rst_ready", b.col_tready_o, 1);
    @(posedge clk);
    #1;

    c1 = mkcol(1, 1, 1); c2 = mkcol(2, 2, 2); c3 = mkcol(3, 3, 3); c4 = mkcol(4, 4, 4);

    // Four-column line, tuser on first.
    add(c1, 0, 1, win_of(bord(c1), c1, c2), 0, 1);
    add(c2, 0, 0, win_of(c1, c2, c3), 0, 0);
    add(c3, 0, 0, win_of(c2, c3, c4), 0, 0);
    add(c4, 1, 0, win_of(c3, c4, bord(c4)), 1, 0);
    run_table("line4");

    // One-pixel line.
    c7 = mkcol(7, 7, 7);
    add(c7, 1, 1, win_of(bord(c7), c7, bord(c7)), 1, 1);
    run_table("line1");

    // Same line with a mid-line consumer stall.
    add(c1, 0, 1, win_of(bord(c1), c1, c2), 0, 1);
    add(c2, 0, 0, win_of(c1, c2, c3), 0, 0);
    add(c3, 0, 0, win_of(c2, c3, c4), 0, 0);
    add(c4, 1, 0, win_of(c3, c4, bord(c4)), 1, 0);
    fork
      run_table("stall");
      stall_seq();
    join

    // Distinct rows; tuser on a non-first column is ignored.
    rw = mkcol(10, 20, 30);
    add(rw, 0, 0, win_of(bord(rw), rw, rw), 0, 0);
    add(rw, 0, 1, win_of(rw, rw, rw), 0, 0);
    add(rw, 1, 0, win_of(rw, rw, bord(rw)), 1, 0);
    run_table("rows");

    // Two back-to-back lines: exactly one input bubble between them.
    d1 = mkcol(1, 2, 3); d2 = mkcol(4, 5, 6); d3 = mkcol(7, 8, 9);
    e1 = mkcol(21, 22, 23); e2 = mkcol(24, 25, 26); e3 = mkcol(27, 28, 29);
    add(d1, 0, 1, win_of(bord(d1), d1, d2), 0, 1);
    add(d2, 0, 0, win_of(d1, d2, d3), 0, 0);
    add(d3, 1, 0, win_of(d2, d3, bord(d3)), 1, 0);
    add(e1, 0, 0, win_of(bord(e1), e1, e2), 0, 0);
    add(e2, 0, 0, win_of(e1, e2, e3), 0, 0);
    add(e3, 1, 0, win_of(e2, e3, bord(e3)), 1, 0);
    nrdy = 0;
    run_table("b2b");
    chk("b2b_bubble", nrdy, 1);

    // Reset after 2 of 5 columns, then a fresh 3-column line.
    put_col(mkcol(9, 9, 9), 0, 1);
    put_col(mkcol(9, 9, 9), 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", b.win_tvalid_o, 0);
    chk("midrst_ready", b.col_tready_o, 1);
    @(posedge clk);
    #1;
    add(d1, 0, 1, win_of(bord(d1), d1, d2), 0, 1);
    add(d2, 0, 0, win_of(d1, d2, d3), 0, 0);
    add(d3, 1, 0, win_of(d2, d3, bord(d3)), 1, 0);
    run_table("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
